// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : alu_pkg
//  Description : Shared types for the RV32IM execute-stage ALU. Holds the
//                5-bit operation encoding, the sequencer state encoding and
//                the helper that flags M-extension opcodes.
//  Revision    : 1.0  initial release
// ============================================================================
package alu_pkg;

   // Operation codes. Bit 4 marks the M-extension group (16..23).
   typedef enum logic [4:0] {
      OP_FWD    = 5'd0,
      OP_ADD    = 5'd1,
      OP_SUB    = 5'd2,
      OP_AND    = 5'd3,
      OP_OR     = 5'd4,
      OP_XOR    = 5'd5,
      OP_SLL    = 5'd6,
      OP_SRL    = 5'd7,
      OP_SRA    = 5'd8,
      OP_SLT    = 5'd9,
      OP_SLTU   = 5'd10,
      OP_MUL    = 5'd16,
      OP_MULH   = 5'd17,
      OP_MULHSU = 5'd18,
      OP_MULHU  = 5'd19,
      OP_DIV    = 5'd20,
      OP_DIVU   = 5'd21,
      OP_REM    = 5'd22,
      OP_REMU   = 5'd23
   } alu_op_e;

   // Sequencer states for the iterative multiply/divide path.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } alu_state_e;

   // M-extension group test. Codes 24..31 also have bit 4 set; the top
   // qualifies this with bit 3 so those stay undefined single-cycle codes.
   function automatic logic is_muldiv(input logic [4:0] op);
      return op[4];
   endfunction

endpackage
`default_nettype wire

// File: rtl/alu_basic_comb.sv
`default_nettype none
// ============================================================================
//  Module      : alu_basic_comb
//  Description : Purely combinational single-cycle ALU operations
//                (FWD, ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU).
//                Any other code yields zero.
//  Ports       : op_i  operation code (alu_op_e encoding)
//                a_i   operand rs1
//                b_i   operand rs2/imm; shifts use b_i[SHW-1:0]
//                y_o   combinational result
//  Revision    : 1.0  initial release
// ============================================================================
module alu_basic_comb
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [4:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] y_o
);

   localparam int SHW = $clog2(WIDTH);

   logic [SHW-1:0] w_shamt;
   logic           w_slt;
   logic           w_sltu;

   // Shift amount is taken modulo WIDTH, as RV32I does.
   assign w_shamt = b_i[SHW-1:0];
   assign w_slt   = ($signed(a_i) < $signed(b_i));
   assign w_sltu  = (a_i < b_i);

   always_comb begin
      y_o = '0;
      case (op_i)
         OP_FWD:  y_o = b_i;
         OP_ADD:  y_o = a_i + b_i;
         OP_SUB:  y_o = a_i - b_i;
         OP_AND:  y_o = a_i & b_i;
         OP_OR:   y_o = a_i | b_i;
         OP_XOR:  y_o = a_i ^ b_i;
         OP_SLL:  y_o = a_i << w_shamt;
         OP_SRL:  y_o = a_i >> w_shamt;
         OP_SRA:  y_o = $signed(a_i) >>> w_shamt;
         OP_SLT:  y_o = {{(WIDTH-1){1'b0}}, w_slt};
         OP_SLTU: y_o = {{(WIDTH-1){1'b0}}, w_sltu};
         default: y_o = '0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_muldiv_seq
//  Description : RV32IM execute-stage ALU. Basic operations complete in one
//                registered cycle; multiply/divide run on a shift-add /
//                restoring-division sequencer over operand magnitudes with a
//                sign fix-up at DONE. Divide-by-zero and signed overflow
//                bypass the iteration.
//  Build macro : ALU_MUL_FAST_EN - when defined, the four multiply ops are
//                computed combinationally with single-cycle latency and the
//                MUL state is never entered. Results are identical.
//  Ports       : CLK        rising-edge clock
//                RESET_N    asynchronous active-low reset
//                IN_VALID   operation request
//                IN_READY   high only in IDLE
//                SELECT     operation code (alu_op_e)
//                DATA1      rs1 / dividend / multiplicand
//                DATA2      rs2/imm / divisor / multiplier
//                OUT_VALID  one-cycle pulse, RESULT valid
//                RESULT     registered result, held until next completion
//                ZERO       registered (RESULT == 0)
//                BUSY       multi-cycle operation in flight
//  Revision    : 1.0  initial release
// ============================================================================
module alu_muldiv_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [4:0]       SELECT,
   input  logic [WIDTH-1:0] DATA1,
   input  logic [WIDTH-1:0] DATA2,
   output logic             OUT_VALID,
   output logic [WIDTH-1:0] RESULT,
   output logic             ZERO,
   output logic             BUSY
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] C_MIN = {1'b1, {(WIDTH-1){1'b0}}};

   // ---------------------------------------------------------------- state
   alu_state_e         state_q,  state_d;
   logic [2*WIDTH-1:0] acc_q,    acc_d;     // product, or {remainder, quotient}
   logic [WIDTH-1:0]   b_q,      b_d;       // multiplicand / divisor magnitude
   alu_op_e            op_q,     op_d;
   logic               neg_q,    neg_d;     // result needs negation at DONE
   logic               fast_q,   fast_d;    // acc_q low half holds final answer
   logic [CW-1:0]      cnt_q,    cnt_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               zero_q,   zero_d;
   logic               valid_q,  valid_d;

   // ------------------------------------------------------ operand decode
   logic             w_accept;
   logic             w_sel_m;
   logic             w_is_div;
   logic             w_is_mul;
   logic             w_iter_mul;
   logic             w_s1;
   logic             w_s2;
   logic             w_neg1;
   logic             w_neg2;
   logic             w_neg_res;
   logic [WIDTH-1:0] w_mag1;
   logic [WIDTH-1:0] w_mag2;
   logic             w_div0;
   logic             w_ovf;
   logic [WIDTH-1:0] w_fast_val;
   logic [WIDTH-1:0] w_basic;
   logic [WIDTH-1:0] w_single;

   assign w_accept = IN_VALID && (state_q == ST_IDLE);
   assign w_sel_m  = is_muldiv(SELECT) && !SELECT[3];
   assign w_is_div = w_sel_m && SELECT[2];
   assign w_is_mul = w_sel_m && !SELECT[2];

   assign w_s1 = (SELECT == OP_MULH) || (SELECT == OP_MULHSU) ||
                 (SELECT == OP_DIV)  || (SELECT == OP_REM);
   assign w_s2 = (SELECT == OP_MULH) || (SELECT == OP_DIV) || (SELECT == OP_REM);

   assign w_neg1 = w_s1 && DATA1[WIDTH-1];
   assign w_neg2 = w_s2 && DATA2[WIDTH-1];
   // Negating MIN yields MIN, which read unsigned is the correct magnitude.
   assign w_mag1 = w_neg1 ? -DATA1 : DATA1;
   assign w_mag2 = w_neg2 ? -DATA2 : DATA2;
   // Remainder follows the dividend; everything else follows sign1^sign2.
   assign w_neg_res = ((SELECT == OP_REM) || (SELECT == OP_REMU)) ? w_neg1
                                                                  : (w_neg1 ^ w_neg2);

   assign w_div0 = (DATA2 == '0);
   assign w_ovf  = ((SELECT == OP_DIV) || (SELECT == OP_REM)) &&
                   (DATA1 == C_MIN) && (DATA2 == '1);
   // SELECT[1] separates REM/REMU from DIV/DIVU. On overflow DATA1 is MIN,
   // which is exactly the DIV answer.
   assign w_fast_val = SELECT[1] ? (w_div0 ? DATA1 : '0)
                                 : (w_div0 ? '1    : DATA1);

   alu_basic_comb #(
      .WIDTH (WIDTH)
   ) u_basic (
      .op_i (SELECT),
      .a_i  (DATA1),
      .b_i  (DATA2),
      .y_o  (w_basic)
   );

   // ------------------------------------------------------- iteration step
   // The accept edge performs the first step straight from the input
   // magnitudes; the remaining WIDTH-1 steps run in MUL/DIV.
   logic               w_idle;
   logic               w_step_div;
   logic [2*WIDTH-1:0] w_src;
   logic [WIDTH-1:0]   w_src_b;
   logic [WIDTH:0]     w_mul_sum;
   logic [2*WIDTH-1:0] w_mul_next;
   logic [WIDTH:0]     w_div_tmp;
   logic               w_div_ge;
   logic [WIDTH-1:0]   w_div_rem;
   logic [2*WIDTH-1:0] w_div_next;
   logic [2*WIDTH-1:0] w_step_next;

   assign w_idle     = (state_q == ST_IDLE);
   assign w_step_div = w_idle ? w_is_div : (state_q == ST_DIV);
   assign w_src      = w_idle ? {{WIDTH{1'b0}}, (w_is_div ? w_mag1 : w_mag2)} : acc_q;
   assign w_src_b    = w_idle ? (w_is_div ? w_mag2 : w_mag1) : b_q;

   // Shift-add: conditionally add multiplicand to the upper half, shift right.
   assign w_mul_sum  = {1'b0, w_src[2*WIDTH-1:WIDTH]} +
                       (w_src[0] ? {1'b0, w_src_b} : {(WIDTH+1){1'b0}});
   assign w_mul_next = {w_mul_sum, w_src[WIDTH-1:1]};

   // Restoring division: shift next dividend bit into the partial remainder.
   // The remainder stays below the divisor, so the difference fits WIDTH bits.
   assign w_div_tmp  = {w_src[2*WIDTH-1:WIDTH], w_src[WIDTH-1]};
   assign w_div_ge   = (w_div_tmp >= {1'b0, w_src_b});
   assign w_div_rem  = w_div_ge ? (w_div_tmp[WIDTH-1:0] - w_src_b) : w_div_tmp[WIDTH-1:0];
   assign w_div_next = {w_div_rem, w_src[WIDTH-2:0], w_div_ge};

   assign w_step_next = w_step_div ? w_div_next : w_mul_next;

   // ------------------------------------------------------- sign fix-up
   logic [2*WIDTH-1:0] w_fin_acc;
   alu_op_e            w_fin_op;
   logic               w_fin_neg;
   logic [2*WIDTH-1:0] w_fin_full;
   logic [WIDTH-1:0]   w_fin_hi;
   logic [WIDTH-1:0]   w_fin_res;

`ifdef ALU_MUL_FAST_EN
   logic [2*WIDTH-1:0] w_fast_prod;

   assign w_fast_prod = {{WIDTH{1'b0}}, w_mag1} * {{WIDTH{1'b0}}, w_mag2};
   // In IDLE the fix-up operates on the combinational product of the
   // request being accepted; otherwise on the divide sequencer's result.
   assign w_fin_acc  = w_idle ? w_fast_prod : acc_q;
   assign w_fin_op   = w_idle ? alu_op_e'(SELECT) : op_q;
   assign w_fin_neg  = w_idle ? w_neg_res : neg_q;
   assign w_single   = w_is_mul ? w_fin_res : w_basic;
   assign w_iter_mul = 1'b0;
`else
   assign w_fin_acc  = acc_q;
   assign w_fin_op   = op_q;
   assign w_fin_neg  = neg_q;
   assign w_single   = w_basic;
   assign w_iter_mul = w_is_mul;
`endif

   // Low half of a negated 2W value equals the negated low half, so the
   // quotient reuses w_fin_full; the remainder needs its own negation.
   assign w_fin_full = w_fin_neg ? -w_fin_acc : w_fin_acc;
   assign w_fin_hi   = w_fin_neg ? -w_fin_acc[2*WIDTH-1:WIDTH] : w_fin_acc[2*WIDTH-1:WIDTH];

   always_comb begin
      w_fin_res = '0;
      case (w_fin_op)
         OP_MUL:                        w_fin_res = w_fin_full[WIDTH-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU:  w_fin_res = w_fin_full[2*WIDTH-1:WIDTH];
         OP_DIV, OP_DIVU:               w_fin_res = w_fin_full[WIDTH-1:0];
         OP_REM, OP_REMU:               w_fin_res = w_fin_hi;
         default:                       w_fin_res = '0;
      endcase
   end

   // ------------------------------------------------------ FSM next state
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      b_d      = b_q;
      op_d     = op_q;
      neg_d    = neg_q;
      fast_d   = fast_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      zero_d   = zero_q;
      valid_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (w_accept) begin
               op_d = alu_op_e'(SELECT);
               if (w_is_div && (w_div0 || w_ovf)) begin
                  state_d = ST_DONE;
                  fast_d  = 1'b1;
                  acc_d   = {{WIDTH{1'b0}}, w_fast_val};
               end else if (w_is_div || w_iter_mul) begin
                  state_d = w_is_div ? ST_DIV : ST_MUL;
                  fast_d  = 1'b0;
                  acc_d   = w_step_next;
                  b_d     = w_is_div ? w_mag2 : w_mag1;
                  neg_d   = w_neg_res;
                  // Count WIDTH-1 was consumed by the accept-edge step.
                  cnt_d   = CW'(WIDTH-2);
               end else begin
                  result_d = w_single;
                  zero_d   = (w_single == '0);
                  valid_d  = 1'b1;
               end
            end
         end

         ST_MUL, ST_DIV: begin
            acc_d = w_step_next;
            if (cnt_q == '0) begin
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         ST_DONE: begin
            result_d = fast_q ? acc_q[WIDTH-1:0] : w_fin_res;
            zero_d   = fast_q ? (acc_q[WIDTH-1:0] == '0) : (w_fin_res == '0);
            valid_d  = 1'b1;
            state_d  = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------- state register
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q  <= ST_IDLE;
         acc_q    <= '0;
         b_q      <= '0;
         op_q     <= OP_FWD;
         neg_q    <= 1'b0;
         fast_q   <= 1'b0;
         cnt_q    <= '0;
         result_q <= '0;
         zero_q   <= 1'b1;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         b_q      <= b_d;
         op_q     <= op_d;
         neg_q    <= neg_d;
         fast_q   <= fast_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         valid_q  <= valid_d;
      end
   end

   assign IN_READY  = (state_q == ST_IDLE);
   assign BUSY      = (state_q != ST_IDLE);
   assign OUT_VALID = valid_q;
   assign RESULT    = result_q;
   assign ZERO      = zero_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_muldiv_seq
//  Description : Scoreboard bench for alu_muldiv_seq. Stimulus pushes the
//                hand-computed result and the cycle it is due; a monitor pops
//                and compares on every OUT_VALID.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_muldiv_seq;
   import alu_pkg::*;

   logic        CLK;
   logic        RESET_N;
   logic        IN_VALID;
   logic        IN_READY;
   logic [4:0]  SELECT;
   logic [31:0] DATA1;
   logic [31:0] DATA2;
   logic        OUT_VALID;
   logic [31:0] RESULT;
   logic        ZERO;
   logic        BUSY;

   alu_muldiv_seq #(.WIDTH(32)) dut (
      .CLK       (CLK),
      .RESET_N   (RESET_N),
      .IN_VALID  (IN_VALID),
      .IN_READY  (IN_READY),
      .SELECT    (SELECT),
      .DATA1     (DATA1),
      .DATA2     (DATA2),
      .OUT_VALID (OUT_VALID),
      .RESULT    (RESULT),
      .ZERO      (ZERO),
      .BUSY      (BUSY)
   );

`ifdef ALU_MUL_FAST_EN
   localparam int LAT_MUL = 1;
`else
   localparam int LAT_MUL = 33;
`endif
   localparam int LAT_DIV  = 33;
   localparam int LAT_FAST = 2;

   typedef struct {
      logic [31:0] val;
      int          due;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(posedge CLK) cyc <= cyc + 1;

   // Monitor: every OUT_VALID must match the oldest outstanding expectation,
   // including the cycle it was due.
   exp_t m_e;
   always @(negedge CLK) begin
      if (OUT_VALID) begin
         checks = checks + 1;
         if (sb.size() == 0) begin
            errors = errors + 1;
            $display("FAIL unexpected_out_valid: got result=%h at cycle %0d, required no output",
                     RESULT, cyc);
         end else begin
            m_e = sb.pop_front();
            if (RESULT !== m_e.val || ZERO !== (m_e.val == 32'h0) || cyc != m_e.due) begin
               errors = errors + 1;
               $display("FAIL %s: got result=%h zero=%b cycle=%0d, required result=%h zero=%b cycle=%0d",
                        m_e.name, RESULT, ZERO, cyc, m_e.val, (m_e.val == 32'h0), m_e.due);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      checks = checks + 1;
      if (got !== want) begin
         errors = errors + 1;
         $display("FAIL %s: got %h, required %h", nm, got, want);
      end
   endtask

   // Drive one request once the DUT is ready; returns just after the accept edge.
   task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_v, input int lat, input string nm);
      int w;
      w = 0;
      @(negedge CLK);
      while (!IN_READY && w < 200) begin
         @(negedge CLK);
         w++;
      end
      if (!IN_READY) begin
         checks = checks + 1;
         errors = errors + 1;
         $display("FAIL %s: IN_READY timeout, got 0, required 1", nm);
      end else begin
         SELECT   = op;
         DATA1    = a;
         DATA2    = b;
         IN_VALID = 1'b1;
         sb.push_back('{val: exp_v, due: cyc + lat, name: nm});
         @(posedge CLK);
         #1;
         IN_VALID = 1'b0;
      end
   endtask

   // IN_READY low and BUSY high for the n cycles following an accept.
   task automatic busy_check(input int n, input string nm);
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         chk({nm, "_ready_low"}, {31'b0, IN_READY}, 32'd0);
         chk({nm, "_busy_high"}, {31'b0, BUSY}, 32'd1);
      end
   endtask

   initial begin
      RESET_N  = 1'b0;
      IN_VALID = 1'b0;
      SELECT   = 5'd0;
      DATA1    = 32'h0;
      DATA2    = 32'h0;

      // Reset state
      repeat (3) @(negedge CLK);
      chk("rst_result",    RESULT,              32'h0);
      chk("rst_zero",      {31'b0, ZERO},       32'd1);
      chk("rst_out_valid", {31'b0, OUT_VALID},  32'd0);
      chk("rst_busy",      {31'b0, BUSY},       32'd0);
      RESET_N = 1'b1;
      @(negedge CLK);
      chk("rst_in_ready",  {31'b0, IN_READY},   32'd1);

      // Single-cycle ops, issued back to back
      issue(OP_ADD,  32'd5,         32'd7,          32'd12,         1, "add_5_7");
      issue(OP_SUB,  32'd3,         32'd3,          32'd0,          1, "sub_3_3");
      issue(OP_SRA,  32'h8000_0000, 32'd4,          32'hF800_0000,  1, "sra_4");
      issue(OP_SRL,  32'h8000_0000, 32'd4,          32'h0800_0000,  1, "srl_4");
      issue(OP_SRL,  32'h8000_0000, 32'd33,         32'h4000_0000,  1, "srl_33");
      issue(OP_SLL,  32'h0000_0001, 32'd33,         32'h0000_0002,  1, "sll_33");
      issue(OP_SLT,  32'hFFFF_FFFF, 32'd1,          32'd1,          1, "slt_m1_1");
      issue(OP_SLTU, 32'hFFFF_FFFF, 32'd1,          32'd0,          1, "sltu_max_1");
      issue(OP_XOR,  32'hF0F0_1234, 32'h0FF0_1234,  32'hFF00_0000,  1, "xor");
      issue(OP_AND,  32'hF0F0_00FF, 32'h0FF0_0F0F,  32'h00F0_000F,  1, "and");
      issue(OP_OR,   32'hF000_0001, 32'h0000_0100,  32'hF000_0101,  1, "or");
      issue(OP_FWD,  32'h1111_1111, 32'hCAFE_BABE,  32'hCAFE_BABE,  1, "fwd");
      issue(5'd11,   32'h1234_5678, 32'h1,          32'h0,          1, "undef_11");
      issue(5'd24,   32'h1234_5678, 32'h1,          32'h0,          1, "undef_24");

      // Multiply
      issue(OP_MULH,   32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, LAT_MUL, "mulh");
      busy_check(LAT_MUL - 1, "mulh");
      issue(OP_MULHU,  32'hFFFF_FFFF, 32'd2, 32'h0000_0001, LAT_MUL, "mulhu");
      busy_check(LAT_MUL - 1, "mulhu");
      issue(OP_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, LAT_MUL, "mulhsu");
      busy_check(LAT_MUL - 1, "mulhsu");
      issue(OP_MUL,    32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, LAT_MUL, "mul_7_m3");
      busy_check(LAT_MUL - 1, "mul");

      // Divide
      issue(OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LAT_DIV, "div_m7_2");
      busy_check(LAT_DIV - 1, "div");
      issue(OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, LAT_DIV, "rem_m7_2");
      issue(OP_DIVU, 32'd100,       32'd7, 32'd14,        LAT_DIV, "divu_100_7");
      issue(OP_REMU, 32'd100,       32'd7, 32'd2,         LAT_DIV, "remu_100_7");

      // Divide corners (fast path)
      issue(OP_DIV,  32'd5,         32'd0,          32'hFFFF_FFFF, LAT_FAST, "div_by_0");
      busy_check(LAT_FAST - 1, "div_by_0");
      issue(OP_REM,  32'd9,         32'd0,          32'd9,         LAT_FAST, "rem_by_0");
      issue(OP_DIVU, 32'd5,         32'd0,          32'hFFFF_FFFF, LAT_FAST, "divu_by_0");
      issue(OP_REMU, 32'd9,         32'd0,          32'd9,         LAT_FAST, "remu_by_0");
      issue(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF,  32'h8000_0000, LAT_FAST, "div_ovf");
      issue(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF,  32'h0,         LAT_FAST, "rem_ovf");

      // Requests held during BUSY with changing operands are ignored
      issue(OP_DIVU, 32'd1000, 32'd10, 32'd100, LAT_DIV, "divu_stall");
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         chk("stall_ready_low", {31'b0, IN_READY}, 32'd0);
         IN_VALID = 1'b1;
         SELECT   = OP_ADD;
         DATA1    = $urandom;
         DATA2    = $urandom;
      end
      @(negedge CLK);
      IN_VALID = 1'b0;

      // Reset in the middle of a divide aborts it without OUT_VALID
      issue(OP_DIV, 32'd1000, 32'd3, 32'd333, LAT_DIV, "div_abort");
      repeat (9) @(negedge CLK);
      RESET_N = 1'b0;
      void'(sb.pop_back());
      @(negedge CLK);
      chk("abort_result", RESULT,             32'h0);
      chk("abort_zero",   {31'b0, ZERO},      32'd1);
      chk("abort_busy",   {31'b0, BUSY},      32'd0);
      RESET_N = 1'b1;
      repeat (40) @(negedge CLK);
      chk("abort_result_held", RESULT,        32'h0);

      // Recovery after abort
      issue(OP_ADD, 32'd1, 32'd1, 32'd2, 1, "add_after_abort");

      begin
         int w;
         w = 0;
         while (sb.size() != 0 && w < 200) begin
            @(negedge CLK);
            w++;
         end
      end
      checks = checks + 1;
      if (sb.size() != 0) begin
         errors = errors + 1;
         $display("FAIL drain: got %0d outstanding results, required 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion by time limit, required finish");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/alu_muldiv_seq.md
Name: alu_muldiv_seq

Overview:
- Parametrised RV32IM execute-stage ALU that succeeds the single-cycle combinational ALU.
- Adds SUB, XOR, SLT/SLTU and the full shift set in a single registered cycle, plus iterative multiply/divide (M extension) run by a state machine.
- Sits in EX. The pipeline stalls on IN_READY=0 and captures the result on OUT_VALID.

Parameters:
- WIDTH, 32, datapath width in bits. Legal: power of two, ≥8.
- SHW, $clog2(WIDTH), shift-amount bits taken from DATA2[SHW-1:0]. This is a derived localparam, not overridable.

Ports:
- CLK  in  1  rising-edge clock
- RESET_N  in  1  asynchronous active-low reset
- IN_VALID  in  1  operation request
- IN_READY  out  1  block can accept; high only in IDLE
- SELECT  in  5  operation code (package enum alu_op)
- DATA1  in  WIDTH  operand rs1 / dividend / multiplicand
- DATA2  in  WIDTH  operand rs2/imm / divisor / multiplier
- OUT_VALID  out  1  one-cycle pulse, RESULT valid
- RESULT  out  WIDTH  registered result, held until the next completion
- ZERO  out  1  registered, (RESULT==0)
- BUSY  out  1  multi-cycle operation in flight

Behaviour:
- Reset (RESET_N=0, async): state=IDLE, RESULT=0, ZERO=1, OUT_VALID=0, BUSY=0, IN_READY=1 after release.
  - Reset mid-operation aborts the operation. No OUT_VALID is produced for it.
- Accept condition: IN_VALID & IN_READY on a rising edge. Operands and SELECT are latched at accept; later input changes are ignored.
- Single-cycle ops, latency 1 (OUT_VALID on the edge after accept, state stays IDLE, back-to-back accepts allowed):
  - FWD=DATA2, ADD, SUB, AND, OR, XOR.
  - SLL, SRL, SRA use DATA2[SHW-1:0].
  - SLT (signed) and SLTU return 1 or 0, zero-extended.
  - Undefined codes give RESULT=0 and still pulse OUT_VALID.
- Multi-cycle ops: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE→MUL or DIV on accept of an M op.
  - MUL/DIV iterate a counter from WIDTH-1 down to 0. Count 0 → DONE.
  - DONE writes RESULT, pulses OUT_VALID, → IDLE.
  - Latency from accept to OUT_VALID = WIDTH+1 cycles (33 at WIDTH=32).
  - BUSY=1 in MUL, DIV and DONE.
- Multiply:
  - Shift-add over magnitudes with a 2·WIDTH-bit product register.
  - Signs are fixed by conditional two's-complement negation at DONE.
  - MUL returns low WIDTH bits. MULH returns high bits, signed×signed. MULHSU is signed×unsigned. MULHU is unsigned×unsigned.
- Divide:
  - Restoring division on magnitudes.
  - Quotient sign = sign1^sign2. Remainder sign = dividend sign.
- Divide boundary cases take a fast path: IDLE→DONE, latency 2, no iteration.
  - Divisor 0: DIV/DIVU give all-ones. REM/REMU give DATA1.
  - Signed overflow (DATA1=MIN, DATA2=-1): DIV gives MIN. REM gives 0.
- ZERO is updated in the same edge as RESULT. ZERO does not change while BUSY.
- OUT_VALID is never asserted for two cycles on one operation.

Optional Feature:
- Macro ALU_MUL_FAST_EN.
- Defined: the four MUL ops are computed combinationally, single-cycle, latency 1, and the MUL state is unused. Divide is unchanged.
- Undefined: iterative multiply as specified above.
- RESULT values are identical in both builds. Only latency differs.

Decomposition:
- Package alu_pkg:
  - alu_op enum with 5-bit codes: FWD=0, ADD=1, SUB=2, AND=3, OR=4, XOR=5, SLL=6, SRL=7, SRA=8, SLT=9, SLTU=10, MUL=16, MULH=17, MULHSU=18, MULHU=19, DIV=20, DIVU=21, REM=22, REMU=23.
  - FSM state enum.
  - Helper is_muldiv(op) = op[4].
- One sub-module, alu_basic_comb: combinational single-cycle operations. The top module registers its output and contains the FSM and the mul/div datapath.

Test Plan:
- Reset: hold RESET_N=0 → RESULT=0, ZERO=1, IN_READY=1. Then ADD 5+7 → OUT_VALID the next cycle, RESULT=12, ZERO=0. Next, SUB 3-3 → RESULT=0, ZERO=1.
- Shifts: SRA 0x8000_0000 by 4 → 0xF800_0000. SRL same operands → 0x0800_0000. Also shift amount 33 → shift by 1. Then SLT -1<1 → 1, SLTU 0xFFFF_FFFF<1 → 0.
- Multiply: MULH 0xFFFF_FFFF×2 → 0xFFFF_FFFF. MULHU same operands → 0x0000_0001. MUL 7×-3 → 0xFFFF_FFEB. Each op: OUT_VALID exactly at accept+33, IN_READY=0 throughout. Repeat with ALU_MUL_FAST_EN defined → latency 1, same values.
- Divide: DIV -7/2 → 0xFFFF_FFFD. REM -7/2 → 0xFFFF_FFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- Divide corners: DIV x/0 → 0xFFFF_FFFF. REM 9/0 → 9. DIV 0x8000_0000/-1 → 0x8000_0000. REM of the same operands → 0. Each at latency 2.
- Abort and stall:
  - Pulse RESET_N low at cycle 10 of a DIV → no OUT_VALID, RESULT=0.
  - IN_VALID held during BUSY → not accepted; operands changed during BUSY do not alter the result.
